// File: rtl/pea_feeder.sv
// rtl/pea_feeder.sv - sequences weight/ifm beats into a PE array and tracks psum validity.
// Optional stride-2 row suppression is enabled by defining PEA_FEEDER_STRIDE2_EN.
module pea_feeder #(
   parameter int COL       = 8,
   parameter int WGT_WIDTH = 24,
   parameter int IFM_WIDTH = 128,
   parameter int PE_LAT    = 2,
   parameter int CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start,
   input  logic [CNT_W-1:0]     cfg_rows,
   input  logic [CNT_W-1:0]     cfg_ic,
   input  logic [CNT_W-1:0]     cfg_oc,
   input  logic                 cfg_stride,
   input  logic                 wgt_valid,
   input  logic [WGT_WIDTH-1:0] wgt_data,
   output logic                 wgt_ready,
   input  logic                 ifm_valid,
   input  logic [IFM_WIDTH-1:0] ifm_data,
   output logic                 ifm_ready,
   output logic                 wgt_read,
   output logic [WGT_WIDTH-1:0] wgt_group,
   output logic                 ifm_read,
   output logic [IFM_WIDTH-1:0] ifm_group,
   output logic [COL-1:0]       pvalid,
   output logic                 ic_done,
   output logic                 oc_done,
   output logic                 stride,
   output logic                 busy,
   output logic                 done
);

`ifdef PEA_FEEDER_STRIDE2_EN
   localparam logic STRIDE_EN = 1'b1;
`else
   localparam logic STRIDE_EN = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, LOAD_WGT, LOAD_IFM, NEXT_IC, DRAIN} state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     rows_q, rows_d, ic_cfg_q, ic_cfg_d, oc_cfg_q, oc_cfg_d;
   logic                 stride_q, stride_d;
   logic [1:0]           wcnt_q, wcnt_d;
   logic [CNT_W-1:0]     row_q, row_d, ic_cnt_q, ic_cnt_d, oc_cnt_q, oc_cnt_d;
   logic                 wgt_read_q, wgt_read_d, ifm_read_q, ifm_read_d;
   logic [WGT_WIDTH-1:0] wgt_group_q, wgt_group_d;
   logic [IFM_WIDTH-1:0] ifm_group_q, ifm_group_d;
   logic [PE_LAT:0]      pv_pipe_q, pv_pipe_d, icd_pipe_q, icd_pipe_d, ocm_pipe_q, ocm_pipe_d;
   logic                 oc_done_q, oc_done_d, done_q, done_d;
   logic                 wgt_hs, ifm_hs, skip_row, last_ic, pv_beat;
   logic [CNT_W-1:0]     last_pv_row;

   assign wgt_ready = (state_q == LOAD_WGT);
   assign ifm_ready = (state_q == LOAD_IFM);
   assign wgt_hs    = wgt_valid & wgt_ready;
   assign ifm_hs    = ifm_valid & ifm_ready;

   // With stride-2 the odd rows are dropped, so an even row count ends on a suppressed beat.
   assign skip_row    = stride_q & row_q[0];
   assign last_ic     = (ic_cnt_q == ic_cfg_q - CNT_W'(1));
   assign last_pv_row = (stride_q && !rows_q[0]) ? rows_q - CNT_W'(2) : rows_q - CNT_W'(1);
   assign pv_beat     = ifm_hs & (row_q >= CNT_W'(2)) & ~skip_row;

   always_comb begin
      state_d     = state_q;
      rows_d      = rows_q;
      ic_cfg_d    = ic_cfg_q;
      oc_cfg_d    = oc_cfg_q;
      stride_d    = stride_q;
      wcnt_d      = wcnt_q;
      row_d       = row_q;
      ic_cnt_d    = ic_cnt_q;
      oc_cnt_d    = oc_cnt_q;
      wgt_read_d  = wgt_hs;
      ifm_read_d  = ifm_hs;
      wgt_group_d = wgt_hs ? wgt_data : wgt_group_q;
      ifm_group_d = ifm_hs ? ifm_data : ifm_group_q;
      pv_pipe_d   = {pv_pipe_q[PE_LAT-1:0], pv_beat};
      icd_pipe_d  = {icd_pipe_q[PE_LAT-1:0], pv_beat & last_ic};
      ocm_pipe_d  = {ocm_pipe_q[PE_LAT-1:0], ifm_hs & last_ic & (row_q == last_pv_row)};
      oc_done_d   = ocm_pipe_q[PE_LAT];
      done_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               rows_d   = cfg_rows;
               ic_cfg_d = cfg_ic;
               oc_cfg_d = cfg_oc;
               stride_d = cfg_stride & STRIDE_EN;
               wcnt_d   = '0;
               row_d    = '0;
               ic_cnt_d = '0;
               oc_cnt_d = '0;
               state_d  = LOAD_WGT;
            end
         end
         LOAD_WGT: begin
            if (wgt_hs) begin
               if (wcnt_q == 2'd2) begin
                  wcnt_d  = '0;
                  state_d = LOAD_IFM;
               end else begin
                  wcnt_d = wcnt_q + 2'd1;
               end
            end
         end
         LOAD_IFM: begin
            if (ifm_hs) begin
               if (row_q == rows_q - CNT_W'(1)) begin
                  row_d   = '0;
                  state_d = NEXT_IC;
               end else begin
                  row_d = row_q + CNT_W'(1);
               end
            end
         end
         NEXT_IC: begin
            if (ic_cnt_q < ic_cfg_q - CNT_W'(1)) begin
               ic_cnt_d = ic_cnt_q + CNT_W'(1);
               state_d  = LOAD_WGT;
            end else if (oc_cnt_q < oc_cfg_q - CNT_W'(1)) begin
               ic_cnt_d = '0;
               oc_cnt_d = oc_cnt_q + CNT_W'(1);
               state_d  = LOAD_WGT;
            end else begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // done lands in the first IDLE cycle so it never overlaps busy
            if (pv_pipe_q == '0 && ocm_pipe_q == '0 && !oc_done_q) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         rows_q      <= '0;
         ic_cfg_q    <= '0;
         oc_cfg_q    <= '0;
         stride_q    <= 1'b0;
         wcnt_q      <= '0;
         row_q       <= '0;
         ic_cnt_q    <= '0;
         oc_cnt_q    <= '0;
         wgt_read_q  <= 1'b0;
         ifm_read_q  <= 1'b0;
         wgt_group_q <= '0;
         ifm_group_q <= '0;
         pv_pipe_q   <= '0;
         icd_pipe_q  <= '0;
         ocm_pipe_q  <= '0;
         oc_done_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rows_q      <= rows_d;
         ic_cfg_q    <= ic_cfg_d;
         oc_cfg_q    <= oc_cfg_d;
         stride_q    <= stride_d;
         wcnt_q      <= wcnt_d;
         row_q       <= row_d;
         ic_cnt_q    <= ic_cnt_d;
         oc_cnt_q    <= oc_cnt_d;
         wgt_read_q  <= wgt_read_d;
         ifm_read_q  <= ifm_read_d;
         wgt_group_q <= wgt_group_d;
         ifm_group_q <= ifm_group_d;
         pv_pipe_q   <= pv_pipe_d;
         icd_pipe_q  <= icd_pipe_d;
         ocm_pipe_q  <= ocm_pipe_d;
         oc_done_q   <= oc_done_d;
         done_q      <= done_d;
      end
   end

   assign wgt_read  = wgt_read_q;
   assign ifm_read  = ifm_read_q;
   assign wgt_group = wgt_group_q;
   assign ifm_group = ifm_group_q;
   assign pvalid    = {COL{pv_pipe_q[PE_LAT]}};
   assign ic_done   = icd_pipe_q[PE_LAT];
   assign oc_done   = oc_done_q;
   assign stride    = stride_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;

endmodule
